// File: rtl/hidden_layer_seq.sv
// Address/strobe sequencer for the hidden-layer pass: walks every hidden unit
// through a full dot product over single-port RAMs and writes each sum back.
module hidden_layer_seq #(
  parameter int NUM_INPUTS = 784,
  parameter int NUM_HIDDEN = 32,
  parameter int IN_AW      = $clog2(NUM_INPUTS),
  parameter int W_AW       = $clog2(NUM_INPUTS * NUM_HIDDEN),
  parameter int H_AW       = $clog2(NUM_HIDDEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [IN_AW-1:0] addr_input,
  output logic [W_AW-1:0]  addr_weight,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [H_AW-1:0]  addr_hidden,
  output logic             act_we
);

  localparam logic [IN_AW-1:0] LAST_I = IN_AW'(NUM_INPUTS - 1);
  localparam logic [H_AW-1:0]  LAST_H = H_AW'(NUM_HIDDEN - 1);

  typedef enum logic [2:0] {IDLE, CLR, MAC, WRITE, DONE} state_t;

  state_t state;
  // Index k=NUM_INPUTS-2 and k=NUM_INPUTS-1 both present i=LAST_I; this flag
  // tells the two MAC cycles apart without a separate cycle counter.
  logic   last;

  // The address outputs are themselves the i/w/h counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mac_clr     <= 1'b0;
      mac_en      <= 1'b0;
      act_we      <= 1'b0;
      addr_input  <= '0;
      addr_weight <= '0;
      addr_hidden <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= CLR;
          busy    <= 1'b1;
          mac_clr <= 1'b1;
        end
        CLR: begin
          state       <= MAC;
          mac_clr     <= 1'b0;
          mac_en      <= 1'b1;
          last        <= 1'b0;
          addr_input  <= addr_input + IN_AW'(1);
          addr_weight <= addr_weight + W_AW'(1);
        end
        MAC: begin
          if (addr_input == LAST_I) begin
            if (last) begin
              state  <= WRITE;
              mac_en <= 1'b0;
              act_we <= 1'b1;
            end else begin
              last <= 1'b1;
            end
          end else begin
            addr_input  <= addr_input + IN_AW'(1);
            addr_weight <= addr_weight + W_AW'(1);
          end
        end
        WRITE: begin
          act_we <= 1'b0;
          last   <= 1'b0;
          if (addr_hidden == LAST_H) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state       <= CLR;
            mac_clr     <= 1'b1;
            addr_hidden <= addr_hidden + H_AW'(1);
            addr_input  <= '0;
            addr_weight <= addr_weight + W_AW'(1);  // next unit's base
          end
        end
        DONE: begin
          state       <= IDLE;
          done        <= 1'b0;
          addr_input  <= '0;
          addr_weight <= '0;
          addr_hidden <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hidden_layer_seq.md
# hidden_layer_seq

Sequencer for the hidden-layer pass of the digit-classifier network. On a start pulse it walks every hidden unit through a full dot product: it drives read addresses into the input-pixel RAM and the hidden-unit weight RAM (both single-port, registered read address, one-cycle read latency), strobes the external MAC clear/enable in alignment with returning RAM data, and writes each finished sum into the hidden activation RAM. It owns no datapath arithmetic; it is the only address master on those RAMs while busy.

## Interface
- NUM_INPUTS, 784, inputs per hidden unit (pixel count)
- NUM_HIDDEN, 32, number of hidden units
- IN_AW, $clog2(NUM_INPUTS) = 10, input RAM address width
- W_AW, $clog2(NUM_INPUTS*NUM_HIDDEN) = 15, weight RAM address width
- H_AW, $clog2(NUM_HIDDEN) = 5, hidden activation RAM address width
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  single-cycle request to run a full hidden-layer pass
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when the pass completes
- addr_input  out  IN_AW  input RAM read address
- addr_weight  out  W_AW  weight RAM read address
- mac_clr  out  1  clear MAC accumulator
- mac_en  out  1  accumulate current RAM q outputs (input × weight)
- addr_hidden  out  H_AW  hidden activation RAM write address
- act_we  out  1  write MAC result to hidden RAM at addr_hidden

## Operation
- States: IDLE, CLR, MAC, WRITE, DONE.
- Counters: i (input index, IN_AW bits), h (hidden index, H_AW bits), w (weight address, W_AW bits). Address outputs are registered counter values.
- IDLE: outputs low, counters 0. start=1 -> CLR; start ignored in all other states.
- CLR (1 cycle): mac_clr=1; addr_input=0, addr_weight=w (= h*NUM_INPUTS, produced by a running counter, never by a multiplier). Next -> MAC.
- MAC (NUM_INPUTS cycles, k = 0..NUM_INPUTS-1): mac_en=1 every cycle, consuming data for index k; addresses present index k+1. At k=NUM_INPUTS-1 addresses hold (i=NUM_INPUTS-1, w=last weight of unit); w does not advance past the unit's last weight. Next -> WRITE.
- WRITE (1 cycle): act_we=1, addr_hidden=h; w advances to the next unit's base; i returns to 0. If h==NUM_HIDDEN-1 -> DONE, else h+=1 -> CLR.
- DONE (1 cycle): done=1, busy=0. Next -> IDLE.
- mac_clr, mac_en and act_we are mutually exclusive in every cycle.
- rst_n=0 in any state: next cycle IDLE, all outputs 0, counters 0; a partial pass is abandoned with no further act_we.

## Timing
- Reset value of every output: 0.
- Start accepted at edge E0 -> CLR visible in cycle 1, busy=1 from cycle 1.
- Per hidden unit: NUM_INPUTS+2 cycles (CLR + MAC + WRITE).
- done pulses in cycle NUM_HIDDEN*(NUM_INPUTS+2)+1 after start (25153 for defaults); busy falls in that same cycle.
- RAM alignment: an address presented in cycle n yields q in cycle n+1; mac_en in cycle n+1 consumes it.
- MAC result is valid in the WRITE cycle (last mac_en was the preceding cycle); act_we writes it at that edge.
- start coinciding with done/DONE cycle is ignored; new start accepted only in IDLE.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with start=1 -> all outputs 0, state IDLE, no busy.
- Small config NUM_INPUTS=4, NUM_HIDDEN=2, start pulse -> addr_weight sequence 0,1,2,3,3 then 4,5,6,7,7; mac_clr at cycles 1,7; mac_en cycles 2-5, 8-11; act_we at 6 (addr_hidden=0) and 12 (addr_hidden=1); done at 13.
- Data-path check with behavioral RAMs and MAC, inputs all 1, weights = address value -> hidden RAM holds 6 and 22.
- start pulsed repeatedly while busy -> ignored; exactly one done, exactly NUM_HIDDEN act_we pulses.
- rst_n low for 1 cycle mid-MAC of unit 1 -> next cycle all outputs 0, no further act_we; subsequent start runs a full clean pass from addr_weight=0.
- Default parameters -> done exactly 25153 cycles after start; final act_we at addr_hidden=31 with last addr_weight=25087.
